// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared widths, tag-width helper and pipeline stage record
package mul_sched_pkg;
  localparam int MUL_W = 32;
  localparam int PROD_W = 64;
  localparam int MAX_TAG_W = 3;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic                 hi;
  } stage_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant searching upward from the last accepted winner
module rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int TW = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant,
  output logic [TW-1:0]      idx
);
  logic [TW-1:0] last_grant;
  logic [TW-1:0] j;
  logic          found;
  // Scanning farthest-first lets the nearest requester after last_grant overwrite idx last.
  always_comb begin
    idx = '0;
    j = '0;
    found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = TW'((int'(last_grant) + k) % NUM_REQ);
      if (req[j]) begin
        idx = j;
        found = 1'b1;
      end
    end
    grant = (enable && found) ? NUM_REQ'(1) << idx : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_grant <= TW'(NUM_REQ - 1);
    else if (advance && |grant) last_grant <= idx;
endmodule

// File: rtl/mul_cell_sched.sv
// mul_cell_sched: round-robin sharing of a two-stage pipelined 32x32 multiply cell
module mul_cell_sched
  import mul_sched_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [MUL_W*NUM_REQ-1:0] req_src1,
  input  logic [MUL_W*NUM_REQ-1:0] req_src2,
  input  logic [NUM_REQ-1:0]       req_src1_signed,
  input  logic [NUM_REQ-1:0]       req_src2_signed,
  input  logic [NUM_REQ-1:0]       req_hi,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [MUL_W-1:0]         rsp_data,
  output logic [MUL_W-1:0]         cell_src1,
  output logic [MUL_W-1:0]         cell_src2,
  output logic                     cell_signa,
  output logic                     cell_signb,
  output logic                     cell_en0,
  output logic                     cell_en1,
  input  logic [PROD_W-1:0]        cell_result
);
  localparam int TW = clog2(NUM_REQ);
  logic               stall;
  logic [NUM_REQ-1:0] grant;
  logic [TW-1:0]      idx;
  logic [TW-1:0]      s2_tag;
  stage_t             s1, s2;
  assign s2_tag = s2.tag[TW-1:0];
  assign stall = s2.valid & ~rsp_ready[s2_tag];
  assign cell_en0 = ~stall;
  assign cell_en1 = ~stall;
  assign req_ready = grant;
  // Gating with reset_n keeps any request from being accepted while reset is held.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req_valid),
    .enable  (~stall & reset_n),
    .advance (~stall),
    .grant   (grant),
    .idx     (idx)
  );
  assign cell_src1 = req_src1[MUL_W*idx +: MUL_W];
  assign cell_src2 = req_src2[MUL_W*idx +: MUL_W];
  assign cell_signa = req_src1_signed[idx];
  assign cell_signb = req_src2_signed[idx];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else if (!stall) begin
      s1 <= '{valid: |grant, tag: MAX_TAG_W'(idx), hi: req_hi[idx]};
      s2 <= s1;
    end
  assign rsp_valid = s2.valid ? NUM_REQ'(1) << s2_tag : '0;
  assign rsp_data = s2.hi ? cell_result[PROD_W-1:MUL_W] : cell_result[MUL_W-1:0];
endmodule

// File: tb/tb_mul_cell_sched.sv
// tb_mul_cell_sched: scoreboard bench with behavioural cell and arithmetic reference model
module tb_mul_cell_sched;
  localparam int N = 4;
  logic            clk = 0;
  logic            reset_n = 0;
  logic [N-1:0]    req_valid = '0, req_ready;
  logic [32*N-1:0] req_src1 = '0, req_src2 = '0;
  logic [N-1:0]    req_src1_signed = '0, req_src2_signed = '0, req_hi = '0;
  logic [N-1:0]    rsp_valid, rsp_ready = '1;
  logic [31:0]     rsp_data, cell_src1, cell_src2;
  logic            cell_signa, cell_signb, cell_en0, cell_en1;
  logic [63:0]     cell_result;

  mul_cell_sched #(.NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_src1_signed(req_src1_signed),
    .req_src2_signed(req_src2_signed), .req_hi(req_hi), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data), .cell_src1(cell_src1),
    .cell_src2(cell_src2), .cell_signa(cell_signa), .cell_signb(cell_signb),
    .cell_en0(cell_en0), .cell_en1(cell_en1), .cell_result(cell_result)
  );

  always #5 clk = ~clk;

  // Behavioural multiply cell: input registers, then product register, aclr from ~reset_n.
  logic [31:0]        ca, cb;
  logic               csa, csb;
  logic signed [65:0] pm;
  assign pm = $signed({csa & ca[31], ca}) * $signed({csb & cb[31], cb});
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ca <= '0; cb <= '0; csa <= 1'b0; csb <= 1'b0; cell_result <= '0;
    end else begin
      if (cell_en0) begin
        ca <= cell_src1; cb <= cell_src2; csa <= cell_signa; csb <= cell_signb;
      end
      if (cell_en1) cell_result <= pm[63:0];
    end

  typedef struct {
    int          tag;
    logic [31:0] data;
    int          cyc;
    int          holds;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0, errors = 0, cyc = 0, holds = 0, ref_last = N - 1;
  logic        prev_held = 1'b0;
  logic [31:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic sa, input logic sb_, input logic hi);
    longint      x, y;
    logic [63:0] p;
    x = sa ? longint'($signed(a)) : longint'({32'b0, a});
    y = sb_ ? longint'($signed(b)) : longint'({32'b0, b});
    p = 64'(x * y);
    return hi ? p[63:32] : p[31:0];
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int last);
    logic [N-1:0] one;
    one = 1;
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return one << ((last + k) % N);
    return '0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", nm, act, expv, cyc);
    end
  endtask

  // Monitor: model arbitration, push expected results, pop and compare on the response side.
  always @(negedge clk) begin
    logic [N-1:0] eg, ov;
    logic         stall;
    if (!reset_n) begin
      sb.delete();
      ref_last = N - 1;
      prev_held = 1'b0;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cell_en", {cell_en0, cell_en1}, 2'b11);
    end else begin
      stall = |(rsp_valid & ~rsp_ready);
      eg = stall ? '0 : rr_pick(req_valid, ref_last);
      chk("req_ready", req_ready, eg);
      chk("cell_en", {cell_en0, cell_en1}, stall ? 2'b00 : 2'b11);
      for (int i = 0; i < N; i++)
        if (eg[i]) begin
          sb.push_back('{i, ref_mul(req_src1[32*i +: 32], req_src2[32*i +: 32],
                                    req_src1_signed[i], req_src2_signed[i], req_hi[i]), cyc, holds});
          ref_last = i;
        end
      if (sb.size() != 0 && cyc == sb[0].cyc + 2 + holds - sb[0].holds) begin
        ov = '0;
        ov[sb[0].tag] = 1'b1;
        chk("rsp_valid", rsp_valid, ov);
        chk("rsp_data", rsp_data, sb[0].data);
        if (prev_held) chk("rsp_hold", rsp_data, prev_data);
        if (rsp_ready[sb[0].tag]) void'(sb.pop_front());
      end else chk("rsp_idle", rsp_valid, 0);
      if (stall) holds++;
      prev_held = stall;
      prev_data = rsp_data;
    end
  end

  task automatic issue(input int r, input logic [31:0] a, input logic [31:0] b,
                       input logic sa, input logic sb_, input logic hi);
    logic ok;
    req_src1[32*r +: 32] = a;
    req_src2[32*r +: 32] = b;
    req_src1_signed[r] = sa;
    req_src2_signed[r] = sb_;
    req_hi[r] = hi;
    req_valid[r] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[r];
      @(posedge clk);
      #1;
    end
    req_valid[r] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL issue_timeout requester=%0d actual=no_grant expected=grant", r);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain", 64'(sb.size()), 0);
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_src1[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      req_src2[32*i +: 32] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
    end
    req_src1_signed = N'($urandom);
    req_src2_signed = N'($urandom);
    req_hi = N'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    issue(0, 32'hFFFF_FFFF, 32'h2, 0, 0, 1);
    issue(0, 32'hFFFF_FFFF, 32'h2, 1, 1, 1);
    issue(0, 32'hFFFF_FFFF, 32'h2, 1, 1, 0);
    drain();
    for (int c = 0; c < 16; c++) begin
      rand_ops();
      req_valid = '1;
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    drain();
    issue(1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 1, 1);
    rsp_ready[1] = 1'b0;
    issue(2, 32'hDEAD_BEEF, 32'h0000_0003, 1, 0, 0);
    repeat (3) @(posedge clk);
    #1 rsp_ready[1] = 1'b1;
    drain();
    issue(2, 32'd7, 32'd6, 0, 0, 0);
    issue(2, 32'h8000_0000, 32'h2, 1, 1, 1);
    drain();
    rand_ops();
    req_valid = '1;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 req_valid = '0;
    drain();
    repeat (10) @(posedge clk);
    #1;
    for (int c = 0; c < 1500; c++) begin
      rand_ops();
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) rsp_ready[i] = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    rsp_ready = '1;
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_cell_sched.md
# mul_cell_sched

Round-robin scheduler that shares one pipelined 32x32 multiply cell (registered inputs, registered 64-bit output, two-cycle latency) between several requesters. It sits between the cell and its clients, for example CPU custom-instruction ports and DMA/checksum engines. Per requester, it accepts operands plus signedness and a high/low select over a valid/ready handshake. It drives the cell's operands, sign bits and both stage enables, tracks ownership of in-flight products, and returns the selected 32-bit half to the issuing requester, stalling the whole pipeline on response backpressure.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.

Ports:
- clk  in  1  single clock for the block and the cell.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request pending, one bit per requester.
- req_ready  out  NUM_REQ  one-hot grant; the request is accepted when valid&ready.
- req_src1  in  32*NUM_REQ  operand A; requester i occupies bits [32i+31:32i].
- req_src2  in  32*NUM_REQ  operand B, packed the same way.
- req_src1_signed  in  NUM_REQ  treat A as signed.
- req_src2_signed  in  NUM_REQ  treat B as signed.
- req_hi  in  NUM_REQ  1 returns product[63:32]; 0 returns product[31:0].
- rsp_valid  out  NUM_REQ  one-hot result valid to the owning requester.
- rsp_ready  in  NUM_REQ  the requester accepts its result.
- rsp_data  out  32  result shared by all requesters; meaningful only with rsp_valid.
- cell_src1, cell_src2  out  32 each  operands to the cell's input registers.
- cell_signa, cell_signb  out  1 each  operand signedness to the cell.
- cell_en0  out  1  input-register enable for the cell.
- cell_en1  out  1  output-register enable for the cell.
- cell_result  in  64  registered product from the cell.

## Operation
- Three stages track the pipeline:
  - S0: combinational issue.
  - S1: operands sit in the cell input registers.
  - S2: product sits in the cell output register.
- S1 and S2 each hold: valid, tag (log2 NUM_REQ bits), hi.
- stall = s2_valid & ~rsp_ready[s2_tag].
- cell_en0 = cell_en1 = ~stall. The pipeline advances as a whole or not at all.
- Arbitration, only when ~stall:
  - The grant goes to the first requester with req_valid set, searching from last_grant+1 upward with wrap-around.
  - req_ready is one-hot on the winner and all zero when stalled or when nothing is requested.
  - req_ready is combinational from req_valid, last_grant and stall. A requester must not make req_valid depend on req_ready.
- The cell_src1/src2/signa/signb mux selects the winner. With no grant it selects requester 0; S1 valid=0 makes the captured data don't-care.
- last_grant updates only on an accepted grant.
- Advance (~stall):
  - S1 <= {granted, winner, req_hi[winner]}.
  - S2 <= S1.
- rsp_valid[s2_tag] = s2_valid.
- rsp_data = s2_hi ? cell_result[63:32] : cell_result[31:0].
- While stalled, cell_result holds (cell_en1=0), so rsp_data is stable.
- Product width rule: the cell computes the full 64-bit product. Signed×unsigned is legal per operand. The low half is identical for all sign modes.
- A requester may have up to 2 results in flight and receives them in issue order. A requester may also be granted on the same cycle its own response is accepted.

## Timing
- Reset (async assert, sync-released by the system) sets:
  - S1/S2 valid=0.
  - last_grant=NUM_REQ-1, so requester 0 wins first.
  - req_ready=0, rsp_valid=0, cell_en0=cell_en1=1.
  - rsp_data is don't-care.
- The cell's aclr must be driven from ~reset_n.
- Latency: grant in cycle T gives rsp_valid in cycle T+2 with no stall. Each stalled cycle adds one.
- Throughput: one grant per cycle while rsp_ready stays high.
- A stall with S1 valid keeps S1; the S1 entry advances the cycle after rsp_ready rises.
- Reset mid-operation discards all in-flight products. No rsp_valid is produced for them after release.
- If the S2 owner drops rsp_ready, the block must not deadlock other requesters' later progress once rsp_ready returns. Head-of-line blocking is accepted by design.

## Structure
- Package mul_sched_pkg holds:
  - MUL_W=32 and PROD_W=64.
  - The tag-width function clog2.
  - The stage record (valid, tag, hi) as a typedef.
- Sub-module rr_arbiter(NUM_REQ): inputs req, enable, advance; outputs one-hot grant and index; owns last_grant.
- Pipeline tracking and result muxing stay in mul_cell_sched.
- The bench uses a behavioural two-register cell model with the same enables.

## Test plan
- Single request: req0 issues 0xFFFFFFFF×0x2, both unsigned, hi=1 -> rsp_valid[0] at T+2, rsp_data=0x00000001. Repeat signed/signed -> 0xFFFFFFFF; with hi=0 -> 0xFFFFFFFE.
- Round-robin: all 4 requesters valid continuously -> grants 0,1,2,3,0,… on consecutive cycles. Each rsp matches its own tag, and one rsp_valid occurs per cycle from T+2.
- Backpressure: req1 in S2 with rsp_ready[1]=0 for 3 cycles -> cell_en0/en1=0, req_ready=0, and rsp_data stable. On release, rsp1 completes, then S1's result follows one cycle later.
- Back-to-back same requester: req2 issues 7×6 then 0x80000000×2 (signed, hi=1) -> rsp_data 42 then 0xFFFFFFFF, in order.
- Reset mid-flight: assert reset_n=0 with S1 and S2 valid -> rsp_valid=0 immediately. After release, no stale rsp appears and requester 0 wins first.
- Idle: no req_valid for 10 cycles -> req_ready=0 and rsp_valid=0 throughout.
